// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the multi-round game controller:
// state codes, the illegal-state code and width helpers.
package unidade_controle_rodadas_pkg;

    typedef enum logic [4:0] {
        INICIAL         = 5'd0,
        RESETA_TUDO     = 5'd1,
        PREPARA_JOGO    = 5'd2,
        ARMAZENA_JOGO   = 5'd3,
        PREPARA_NOITE   = 5'd5,
        PROXIMO_JOGADOR = 5'd6,
        TURNO_NOITE     = 5'd7,
        DELAY_NOITE     = 5'd9,
        BUSCA_JOGADOR   = 5'd10,
        RESOLVE_NOITE   = 5'd11,
        CHECA_NOITE     = 5'd12,
        DIA             = 5'd13,
        VOTACAO         = 5'd14,
        RESOLVE_DIA     = 5'd15,
        CHECA_DIA       = 5'd16,
        FIM_JOGO        = 5'd17
    } estado_t;

    localparam logic [4:0] ESTADO_ERRO = 5'b11111;

    // clog2 with a floor of one bit, so tiny ranges still get a vector
    function automatic int largura(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unidade_controle_rodadas_if.sv
// Handshake and status bundle between the button front-end,
// the game datapath and the round controller.
interface unidade_controle_rodadas_if
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int N_JOGADORES = 8,
    parameter int MAX_RODADAS = 15
);
    localparam int JW = largura(N_JOGADORES);
    localparam int RW = largura(MAX_RODADAS + 1);

    logic                   jogar;
    logic                   passa;
    logic [N_JOGADORES-1:0] vivo;
    logic                   vitoria_lobos;
    logic                   vitoria_aldeia;

    logic                   rst_global;
    logic                   zera_CS;
    logic                   inc_seed;
    logic                   e_seed_reg;
    logic                   mostra_classe;
    logic                   processar_acao;
    logic                   mostra_dia;
    logic                   habilita_voto;
    logic                   aplica_noite;
    logic                   aplica_votacao;
    logic                   timeout;
    logic                   fim_jogo;
    logic [JW-1:0]          jogador_atual;
    logic [RW-1:0]          rodada;
    logic [4:0]             db_estado;

    modport master (
        output jogar, passa, vivo, vitoria_lobos, vitoria_aldeia,
        input  rst_global, zera_CS, inc_seed, e_seed_reg,
        input  mostra_classe, processar_acao, mostra_dia, habilita_voto,
        input  aplica_noite, aplica_votacao, timeout, fim_jogo,
        input  jogador_atual, rodada, db_estado
    );

    modport slave (
        input  jogar, passa, vivo, vitoria_lobos, vitoria_aldeia,
        output rst_global, zera_CS, inc_seed, e_seed_reg,
        output mostra_classe, processar_acao, mostra_dia, habilita_voto,
        output aplica_noite, aplica_votacao, timeout, fim_jogo,
        output jogador_atual, rodada, db_estado
    );

endinterface

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-turn timeout: loaded on entry to a waiting state, counts down
// while enabled and flags expiry on the last allowed cycle.
module contador_timeout
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_limpa,
    input  logic i_habilita,
    output logic o_expira
);
    localparam int CW = largura(TIMEOUT_CICLOS + 1);
    localparam int CARGA_INT = (TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0;
    localparam logic [CW-1:0] CARGA = CW'(CARGA_INT);

    logic [CW-1:0] r_conta;

    // reload on clear, otherwise count down to zero and hold there
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_conta <= '0;
        end else if (i_limpa) begin
            r_conta <= CARGA;
        end else if (i_habilita && (r_conta != '0)) begin
            r_conta <= r_conta - 1'b1;
        end
    end

    // a zero limit means the wait never expires
    assign o_expira = (TIMEOUT_CICLOS != 0) && i_habilita && (r_conta == '0);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Multi-round match controller: seed capture, then night turns and
// day votes with dead-player skipping, round count and turn timeout.
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int N_JOGADORES    = 8,
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int MAX_RODADAS    = 15
) (
    input  logic                        clock,
    input  logic                        reset,
    unidade_controle_rodadas_if.slave   bus
);
    localparam int JW = largura(N_JOGADORES);
    localparam int RW = largura(MAX_RODADAS + 1);
    localparam logic [JW-1:0] ULTIMO = JW'(N_JOGADORES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RODADAS);

    estado_t       r_estado;
    estado_t       w_prox;
    logic [JW-1:0] r_jogador;
    logic [RW-1:0] r_rodada;

    logic w_ultimo;
    logic w_vivo_atual;
    logic w_vence;
    logic w_espera;
    logic w_limpa;
    logic w_expira;
    logic [4:0] w_db;

    logic w_rst_global;
    logic w_zera_cs;
    logic w_inc_seed;
    logic w_e_seed;
    logic w_noite;
    logic w_mostra_dia;
    logic w_hab_voto;
    logic w_aplica_noite;
    logic w_aplica_voto;
    logic w_fim;

    assign w_ultimo     = (r_jogador == ULTIMO);
    assign w_vivo_atual = bus.vivo[r_jogador];
    assign w_vence      = bus.vitoria_lobos | bus.vitoria_aldeia;
    assign w_espera     = (r_estado == TURNO_NOITE) || (r_estado == VOTACAO);
    assign w_limpa      = ((r_estado == DELAY_NOITE) || (r_estado == DIA))
                          && bus.passa;

    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .i_limpa    (w_limpa),
        .i_habilita (w_espera),
        .o_expira   (w_expira)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    // next-state logic; unknown codes fall back to INICIAL
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:         if (bus.jogar) w_prox = RESETA_TUDO;
            RESETA_TUDO:     w_prox = PREPARA_JOGO;
            PREPARA_JOGO:    if (bus.passa) w_prox = ARMAZENA_JOGO;
            ARMAZENA_JOGO:   w_prox = PREPARA_NOITE;
            PREPARA_NOITE:   w_prox = BUSCA_JOGADOR;
            BUSCA_JOGADOR: begin
                if (w_vivo_atual)  w_prox = DELAY_NOITE;
                else if (w_ultimo) w_prox = RESOLVE_NOITE;
            end
            DELAY_NOITE:     if (bus.passa) w_prox = TURNO_NOITE;
            TURNO_NOITE:     if (bus.passa || w_expira) w_prox = PROXIMO_JOGADOR;
            PROXIMO_JOGADOR: w_prox = w_ultimo ? RESOLVE_NOITE : BUSCA_JOGADOR;
            RESOLVE_NOITE:   w_prox = CHECA_NOITE;
            CHECA_NOITE:     w_prox = w_vence ? FIM_JOGO : DIA;
            DIA:             if (bus.passa) w_prox = VOTACAO;
            VOTACAO:         if (bus.passa || w_expira) w_prox = RESOLVE_DIA;
            RESOLVE_DIA:     w_prox = CHECA_DIA;
            CHECA_DIA:       w_prox = w_vence ? FIM_JOGO : PREPARA_NOITE;
            FIM_JOGO:        if (bus.jogar) w_prox = RESETA_TUDO;
            default:         w_prox = INICIAL;
        endcase
    end

    // player index and round counter updates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_jogador <= '0;
            r_rodada  <= '0;
        end else begin
            case (r_estado)
                RESETA_TUDO: r_rodada <= '0;
                PREPARA_NOITE: begin
                    r_jogador <= '0;
                    if (r_rodada < R_MAX) r_rodada <= r_rodada + 1'b1;
                end
                BUSCA_JOGADOR:
                    if (!w_vivo_atual && !w_ultimo) r_jogador <= r_jogador + 1'b1;
                PROXIMO_JOGADOR:
                    if (!w_ultimo) r_jogador <= r_jogador + 1'b1;
                default: ;
            endcase
        end
    end

    // Moore strobes decoded from the current state
    always_comb begin
        w_rst_global   = 1'b0;
        w_zera_cs      = 1'b0;
        w_inc_seed     = 1'b0;
        w_e_seed       = 1'b0;
        w_noite        = 1'b0;
        w_mostra_dia   = 1'b0;
        w_hab_voto     = 1'b0;
        w_aplica_noite = 1'b0;
        w_aplica_voto  = 1'b0;
        w_fim          = 1'b0;
        case (r_estado)
            INICIAL, RESETA_TUDO: begin
                w_rst_global = 1'b1;
                w_zera_cs    = 1'b1;
            end
            PREPARA_JOGO:  w_inc_seed     = 1'b1;
            ARMAZENA_JOGO: w_e_seed       = 1'b1;
            TURNO_NOITE:   w_noite        = 1'b1;
            DIA:           w_mostra_dia   = 1'b1;
            VOTACAO:       w_hab_voto     = 1'b1;
            RESOLVE_NOITE: w_aplica_noite = 1'b1;
            RESOLVE_DIA:   w_aplica_voto  = 1'b1;
            FIM_JOGO:      w_fim          = 1'b1;
            default: ;
        endcase
    end

    // debug state code, flagging anything outside the legal set
    always_comb begin
        w_db = ESTADO_ERRO;
        case (r_estado)
            INICIAL, RESETA_TUDO, PREPARA_JOGO, ARMAZENA_JOGO,
            PREPARA_NOITE, PROXIMO_JOGADOR, TURNO_NOITE, DELAY_NOITE,
            BUSCA_JOGADOR, RESOLVE_NOITE, CHECA_NOITE, DIA,
            VOTACAO, RESOLVE_DIA, CHECA_DIA, FIM_JOGO:
                w_db = r_estado;
            default: w_db = ESTADO_ERRO;
        endcase
    end

    assign bus.rst_global     = w_rst_global;
    assign bus.zera_CS        = w_zera_cs;
    assign bus.inc_seed       = w_inc_seed;
    assign bus.e_seed_reg     = w_e_seed;
    assign bus.mostra_classe  = w_noite;
    assign bus.processar_acao = w_noite;
    assign bus.mostra_dia     = w_mostra_dia;
    assign bus.habilita_voto  = w_hab_voto;
    assign bus.aplica_noite   = w_aplica_noite;
    assign bus.aplica_votacao = w_aplica_voto;
    assign bus.timeout        = w_espera && w_expira && !bus.passa;
    assign bus.fim_jogo       = w_fim;
    assign bus.jogador_atual  = r_jogador;
    assign bus.rodada         = r_rodada;
    assign bus.db_estado      = w_db;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for the round controller: spec-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_unidade_controle_rodadas;
    import unidade_controle_rodadas_pkg::*;

    localparam int N    = 8;
    localparam int T    = 10;
    localparam int MAXR = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    unidade_controle_rodadas_if #(
        .N_JOGADORES (N),
        .MAX_RODADAS (MAXR)
    ) bus ();

    unidade_controle_rodadas #(
        .N_JOGADORES    (N),
        .TIMEOUT_CICLOS (T),
        .MAX_RODADAS    (MAXR)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nome, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nome, act, exp, $time);
        end
    endtask

    // model: current phase, player, round and cycles spent waiting
    int m_st = 0;
    int m_j  = 0;
    int m_r  = 0;
    int m_c  = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_j = 0; m_r = 0; m_c = 0;
        end else begin
            case (m_st)
                0:  if (bus.jogar) m_st = 1;
                1:  begin m_r = 0; m_st = 2; end
                2:  if (bus.passa) m_st = 3;
                3:  m_st = 5;
                5:  begin
                        m_j = 0;
                        m_r = (m_r < MAXR) ? m_r + 1 : MAXR;
                        m_st = 10;
                    end
                10: if (bus.vivo[m_j]) m_st = 9;
                    else if (m_j == N - 1) m_st = 11;
                    else m_j = m_j + 1;
                9:  if (bus.passa) begin m_c = 0; m_st = 7; end
                7, 14: begin
                        if (bus.passa || (T != 0 && m_c == T - 1))
                            m_st = (m_st == 7) ? 6 : 15;
                        m_c = m_c + 1;
                    end
                6:  if (m_j == N - 1) m_st = 11;
                    else begin m_j = m_j + 1; m_st = 10; end
                11: m_st = 12;
                12: m_st = (bus.vitoria_lobos || bus.vitoria_aldeia) ? 17 : 13;
                13: if (bus.passa) begin m_c = 0; m_st = 14; end
                15: m_st = 16;
                16: m_st = (bus.vitoria_lobos || bus.vitoria_aldeia) ? 17 : 5;
                17: if (bus.jogar) m_st = 1;
                default: m_st = 0;
            endcase
        end
    end

    function automatic logic [11:0] esperado(input int st, input int c,
                                             input logic p);
        logic rg, to;
        rg = (st == 0) || (st == 1);
        to = (st == 7 || st == 14) && (T != 0) && (c == T - 1) && !p;
        return {rg, rg, st == 2, st == 3, st == 7, st == 7, st == 13,
                st == 14, st == 11, st == 15, to, st == 17};
    endfunction

    // per-cycle comparison against the model
    always @(negedge clock) begin
        chk("db_estado", bus.db_estado, m_st);
        chk("jogador_atual", bus.jogador_atual, m_j);
        chk("rodada", bus.rodada, m_r);
        chk("strobes",
            {bus.rst_global, bus.zera_CS, bus.inc_seed, bus.e_seed_reg,
             bus.mostra_classe, bus.processar_acao, bus.mostra_dia,
             bus.habilita_voto, bus.aplica_noite, bus.aplica_votacao,
             bus.timeout, bus.fim_jogo},
            esperado(m_st, m_c, bus.passa));
    end

    // night-turn entries and night-resolution pulses
    int turnos[$];
    int n_noite = 0;
    int prev_st = 0;

    always @(negedge clock) begin
        if (bus.db_estado == 5'd7 && prev_st != 7)
            turnos.push_back(int'(bus.jogador_atual));
        if (bus.aplica_noite) n_noite++;
        prev_st = int'(bus.db_estado);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulse_passa();
        bus.passa = 1'b1;
        tick();
        bus.passa = 1'b0;
    endtask

    task automatic pulse_jogar();
        bus.jogar = 1'b1;
        tick();
        bus.jogar = 1'b0;
    endtask

    task automatic espera(input int code, input int limite);
        int k;
        k = 0;
        while (bus.db_estado != code && k < limite) begin
            tick();
            k++;
        end
        chk($sformatf("espera_%0d", code), bus.db_estado, code);
    endtask

    task automatic avanca_ate(input int code, input int limite);
        int k;
        k = 0;
        while (bus.db_estado != code && k < limite) begin
            if (bus.db_estado inside {5'd7, 5'd9, 5'd13, 5'd14}) pulse_passa();
            else tick();
            k++;
        end
        chk($sformatf("avanca_%0d", code), bus.db_estado, code);
    endtask

    int n7;
    int nto;
    int exp_turnos[6] = '{0, 2, 4, 5, 6, 7};

    initial begin
        bus.jogar = 0;
        bus.passa = 0;
        bus.vivo = '1;
        bus.vitoria_lobos = 0;
        bus.vitoria_aldeia = 0;
        tick(2);
        reset = 1'b1;
        tick();
        chk("rst_estado", bus.db_estado, 0);
        chk("rst_global", bus.rst_global, 1);
        chk("rst_zera", bus.zera_CS, 1);
        chk("rst_rodada", bus.rodada, 0);
        chk("rst_jogador", bus.jogador_atual, 0);

        pulse_jogar();
        chk("ini_1", bus.db_estado, 1);
        tick();
        chk("ini_2", bus.db_estado, 2);
        chk("inc_seed_2", bus.inc_seed, 1);
        tick();
        chk("ini_2b", bus.db_estado, 2);
        pulse_passa();
        chk("ini_3", bus.db_estado, 3);
        chk("inc_seed_3", bus.inc_seed, 0);
        chk("e_seed_3", bus.e_seed_reg, 1);
        tick();
        chk("ini_5", bus.db_estado, 5);
        tick();
        chk("ini_10", bus.db_estado, 10);
        chk("rodada_1", bus.rodada, 1);
        tick();
        chk("ini_9", bus.db_estado, 9);
        chk("jog_0", bus.jogador_atual, 0);

        turnos.delete();
        n_noite = 0;
        bus.vivo = 8'b1111_0101;
        pulse_passa();
        n7 = 0;
        nto = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.db_estado == 5'd7) n7++;
            if (bus.timeout) nto++;
            tick();
        end
        chk("to_ciclos_7", n7, 10);
        chk("to_pulsos", nto, 1);
        chk("to_pos_estado", bus.db_estado, 9);
        chk("to_pos_jog", bus.jogador_atual, 2);

        pulse_passa();
        nto = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.timeout) nto++;
            tick();
        end
        bus.passa = 1'b1;
        #1;
        if (bus.timeout) nto++;
        chk("passa10_estado", bus.db_estado, 7);
        tick();
        bus.passa = 1'b0;
        chk("passa10_sem_to", nto, 0);
        chk("passa10_6", bus.db_estado, 6);

        avanca_ate(11, 200);
        tick();
        chk("noite_12", bus.db_estado, 12);
        chk("aplica_noite_1", n_noite, 1);
        chk("turnos_n", turnos.size(), 6);
        for (int i = 0; i < 6 && i < turnos.size(); i++)
            chk($sformatf("turno_%0d", i), turnos[i], exp_turnos[i]);

        tick();
        chk("dia_13", bus.db_estado, 13);
        chk("mostra_dia", bus.mostra_dia, 1);
        pulse_passa();
        chk("voto_14", bus.habilita_voto, 1);
        nto = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.timeout) nto++;
            tick();
        end
        chk("voto_to", nto, 1);
        chk("voto_5", bus.db_estado, 5);
        tick();
        chk("rodada_2", bus.rodada, 2);

        bus.vivo = '0;
        espera(11, 20);
        chk("mortos_jog7", bus.jogador_atual, 7);
        for (int r = 0; r < 20; r++) begin
            espera(13, 20);
            pulse_passa();
            pulse_passa();
            espera(10, 20);
        end
        chk("rodada_sat", bus.rodada, 15);

        espera(12, 20);
        bus.vitoria_lobos = 1'b1;
        tick();
        bus.vitoria_lobos = 1'b0;
        chk("fim_17", bus.db_estado, 17);
        chk("fim_jogo", bus.fim_jogo, 1);
        for (int i = 0; i < 3; i++) pulse_passa();
        chk("fim_passa", bus.db_estado, 17);
        chk("fim_rodada", bus.rodada, 15);
        chk("fim_jog", bus.jogador_atual, 7);
        pulse_jogar();
        chk("rejoga_1", bus.db_estado, 1);
        tick();
        chk("rejoga_rodada0", bus.rodada, 0);

        bus.vivo = 8'h01;
        pulse_passa();
        avanca_ate(16, 100);
        bus.vitoria_aldeia = 1'b1;
        tick();
        bus.vitoria_aldeia = 1'b0;
        chk("aldeia_17", bus.db_estado, 17);
        chk("aldeia_rodada", bus.rodada, 1);

        pulse_jogar();
        tick();
        pulse_passa();
        avanca_ate(14, 100);
        tick(3);
        #1;
        reset = 1'b0;
        #1;
        chk("async_estado", bus.db_estado, 0);
        chk("async_jog", bus.jogador_atual, 0);
        chk("async_rodada", bus.rodada, 0);
        chk("async_rst_global", bus.rst_global, 1);
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("pos_reset", bus.db_estado, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
